// File: rtl/kmu_dcr_launcher_if.sv
// VX_dcr_bus_if: write-only DCR bus carried from the kernel launcher to the
// device configuration registers. There is no ready/back-pressure signal;
// every cycle with write_valid high is one completed register write.

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif

interface VX_dcr_bus_if;
    logic                          write_valid;
    logic [`VX_DCR_ADDR_WIDTH-1:0] write_addr;
    logic [31:0]                   write_data;

    modport master (
        output write_valid,
        output write_addr,
        output write_data
    );

    modport slave (
        input write_valid,
        input write_addr,
        input write_data
    );
endinterface

// File: rtl/kmu_dcr_launcher.sv
// kmu_dcr_launcher: accepts one kernel launch descriptor at a time and
// replays it onto the DCR bus as eight register writes:
// STARTUP_ADDR0, GRID_DIM0..2, BLOCK_DIM0..2 and finally STARTUP_ARG0.
// ARG0 always goes last because the receiver starts the kernel on it.
// WRITE_GAP idle cycles are inserted between consecutive writes.
//
// Optional feature, macro KMU_DCR_DIFF_EN: keep a shadow copy of the last
// value written to each of the seven non-ARG0 registers and skip entries
// whose value has not changed since the previous write. Skipped entries
// cost no cycles. Without the macro every launch writes all eight registers.

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif

module kmu_dcr_launcher #(
    parameter int WRITE_GAP = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      req_param,
    input  logic [2:0][31:0] req_grid_dim,
    input  logic [2:0][31:0] req_block_dim,
    VX_dcr_bus_if.master     dcr_bus_if,
    output logic             busy,
    output logic             done
);

    localparam int AW = `VX_DCR_ADDR_WIDTH;

    localparam logic [AW-1:0] ADDR_STARTUP_ADDR0 = AW'('h001);
    localparam logic [AW-1:0] ADDR_STARTUP_ARG0  = AW'('h003);
    localparam logic [AW-1:0] ADDR_GRID_DIM0     = AW'('h008);
    localparam logic [AW-1:0] ADDR_GRID_DIM1     = AW'('h009);
    localparam logic [AW-1:0] ADDR_GRID_DIM2     = AW'('h00A);
    localparam logic [AW-1:0] ADDR_BLOCK_DIM0    = AW'('h00B);
    localparam logic [AW-1:0] ADDR_BLOCK_DIM1    = AW'('h00C);
    localparam logic [AW-1:0] ADDR_BLOCK_DIM2    = AW'('h00D);

    // Entry 7 is ARG0, the launch trigger; it is never skipped.
    localparam logic [2:0] LAST_ENTRY = 3'd7;

    // The gap counter counts down from WRITE_GAP-1 to 0, one GAP cycle each.
    localparam logic [3:0] GAP_LOAD = (WRITE_GAP > 0) ? 4'(WRITE_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        idx_q;
    logic [3:0]        gapCnt_q;
    logic [7:0][31:0]  descVals_q;
    logic              writeValid_q;
    logic [AW-1:0]     writeAddr_q;
    logic [31:0]       writeData_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0][31:0]  newVals;
    logic [7:0]        skipCur;
    logic [7:0]        skipNew;
    logic [2:0]        firstNew;
    logic [2:0]        nextCur;
    logic              issue_d;
    logic [2:0]        issueIdx_d;
    logic [31:0]       issueData_d;

    // Map a write-sequence position to its DCR address.
    function automatic logic [AW-1:0] entryAddr(input logic [2:0] idx);
        logic [AW-1:0] result;
        case (idx)
            3'd0:    result = ADDR_STARTUP_ADDR0;
            3'd1:    result = ADDR_GRID_DIM0;
            3'd2:    result = ADDR_GRID_DIM1;
            3'd3:    result = ADDR_GRID_DIM2;
            3'd4:    result = ADDR_BLOCK_DIM0;
            3'd5:    result = ADDR_BLOCK_DIM1;
            3'd6:    result = ADDR_BLOCK_DIM2;
            default: result = ADDR_STARTUP_ARG0;
        endcase
        return result;
    endfunction

    // Lowest entry at or after start that is not skipped; ARG0 always qualifies.
    function automatic logic [2:0] firstPending(input logic [3:0] start, input logic [7:0] skip);
        logic [2:0] result;
        logic       found;
        result = LAST_ENTRY;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && (i >= int'(start)) && !skip[i]) begin
                result = 3'(i);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign newVals = {req_param,
                      req_block_dim[2], req_block_dim[1], req_block_dim[0],
                      req_grid_dim[2],  req_grid_dim[1],  req_grid_dim[0],
                      req_pc};

`ifdef KMU_DCR_DIFF_EN
    logic [6:0][31:0] shadowVal_q;
    logic [6:0]       shadowOk_q;

    // Flag entries of the live and incoming descriptors that match what the registers already hold.
    always_comb begin
        skipCur = '0;
        skipNew = '0;
        for (int i = 0; i < 7; i++) begin
            skipCur[i] = shadowOk_q[i] && (shadowVal_q[i] == descVals_q[i]);
            skipNew[i] = shadowOk_q[i] && (shadowVal_q[i] == newVals[i]);
        end
    end

    // Record every issued non-ARG0 write; reset forgets everything so the next launch writes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadowVal_q <= '0;
            shadowOk_q  <= '0;
        end else if (issue_d && (issueIdx_d != LAST_ENTRY)) begin
            shadowVal_q[issueIdx_d] <= issueData_d;
            shadowOk_q[issueIdx_d]  <= 1'b1;
        end
    end
`else
    assign skipCur = '0;
    assign skipNew = '0;
`endif

    assign firstNew = firstPending(4'd0, skipNew);
    assign nextCur  = firstPending({1'b0, idx_q} + 4'd1, skipCur);

    // Decide whether a write is launched at the coming edge and which entry it carries.
    always_comb begin
        issue_d     = 1'b0;
        issueIdx_d  = firstNew;
        issueData_d = newVals[firstNew];
        case (state_q)
            ST_IDLE: begin
                issue_d = req_valid;
            end
            ST_WRITE: begin
                if ((idx_q != LAST_ENTRY) && (WRITE_GAP == 0)) begin
                    issue_d     = 1'b1;
                    issueIdx_d  = nextCur;
                    issueData_d = descVals_q[nextCur];
                end
            end
            ST_GAP: begin
                if (gapCnt_q == 4'd0) begin
                    issue_d     = 1'b1;
                    issueIdx_d  = idx_q;
                    issueData_d = descVals_q[idx_q];
                end
            end
            default: begin
                issue_d = 1'b0;
            end
        endcase
    end

    // Launch sequencer: walks the write list, inserts gaps and pulses done after ARG0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            gapCnt_q     <= 4'd0;
            descVals_q   <= '0;
            writeValid_q <= 1'b0;
            writeAddr_q  <= '0;
            writeData_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            writeValid_q <= issue_d;
            writeAddr_q  <= issue_d ? entryAddr(issueIdx_d) : '0;
            writeData_q  <= issue_d ? issueData_d : 32'd0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        descVals_q <= newVals;
                        idx_q      <= firstNew;
                        busy_q     <= 1'b1;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (idx_q == LAST_ENTRY) begin
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (WRITE_GAP == 0) begin
                        idx_q <= nextCur;
                    end else begin
                        idx_q    <= nextCur;
                        gapCnt_q <= GAP_LOAD;
                        state_q  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gapCnt_q == 4'd0) begin
                        state_q <= ST_WRITE;
                    end else begin
                        gapCnt_q <= gapCnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready              = (state_q == ST_IDLE);
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign dcr_bus_if.write_valid = writeValid_q;
    assign dcr_bus_if.write_addr  = writeAddr_q;
    assign dcr_bus_if.write_data  = writeData_q;

endmodule

// File: tb/tb_kmu_dcr_launcher.sv
// tb_kmu_dcr_launcher: two launchers (WRITE_GAP=0 and WRITE_GAP=2) driven by
// directed launches. Expected DCR writes and done pulses are queued when a
// descriptor is accepted and consumed as the DUT produces them. Built with
// KMU_DCR_DIFF_EN the expected write lists follow the shadow-skip behaviour.

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif

module tb_kmu_dcr_launcher;

    localparam int AW = `VX_DCR_ADDR_WIDTH;

`ifdef KMU_DCR_DIFF_EN
    localparam bit DIFF_EN = 1'b1;
`else
    localparam bit DIFF_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      param;
        logic [2:0][31:0] grid;
        logic [2:0][31:0] block;
    } desc_t;

    typedef struct {
        bit            isDone;
        int            at;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } evt_t;

    logic             clk;
    logic             reset;
    logic             reqValid0;
    logic             reqValid1;
    logic             reqReady0;
    logic             reqReady1;
    logic [31:0]      reqPc;
    logic [31:0]      reqParam;
    logic [2:0][31:0] reqGrid;
    logic [2:0][31:0] reqBlock;
    logic             busy0;
    logic             busy1;
    logic             done0;
    logic             done1;

    VX_dcr_bus_if bus0 ();
    VX_dcr_bus_if bus1 ();

    kmu_dcr_launcher #(.WRITE_GAP(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (reqValid0),
        .req_ready    (reqReady0),
        .req_pc       (reqPc),
        .req_param    (reqParam),
        .req_grid_dim (reqGrid),
        .req_block_dim(reqBlock),
        .dcr_bus_if   (bus0),
        .busy         (busy0),
        .done         (done0)
    );

    kmu_dcr_launcher #(.WRITE_GAP(2)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (reqValid1),
        .req_ready    (reqReady1),
        .req_pc       (reqPc),
        .req_param    (reqParam),
        .req_grid_dim (reqGrid),
        .req_block_dim(reqBlock),
        .dcr_bus_if   (bus1),
        .busy         (busy1),
        .done         (done1)
    );

    evt_t        expQ0[$];
    evt_t        expQ1[$];
    int          errors;
    int          checks;
    int          cyc;
    bit          checksOn;
    int          busyFrom[2];
    int          busyTo[2];
    logic [31:0] shVal[2][7];
    bit          shOk[2][7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [AW-1:0] addrOf(input int i);
        logic [AW-1:0] a;
        case (i)
            0:       a = AW'('h001);
            1:       a = AW'('h008);
            2:       a = AW'('h009);
            3:       a = AW'('h00A);
            4:       a = AW'('h00B);
            5:       a = AW'('h00C);
            6:       a = AW'('h00D);
            default: a = AW'('h003);
        endcase
        return a;
    endfunction

    function automatic desc_t makeDesc(input logic [31:0] pc, input logic [31:0] param,
                                       input logic [31:0] g0, input logic [31:0] g1, input logic [31:0] g2,
                                       input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        desc_t ds;
        ds.pc       = pc;
        ds.param    = param;
        ds.grid[0]  = g0;
        ds.grid[1]  = g1;
        ds.grid[2]  = g2;
        ds.block[0] = b0;
        ds.block[1] = b1;
        ds.block[2] = b2;
        return ds;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Queue the writes and done pulse a descriptor accepted in cycle t0 must produce.
    task automatic pushLaunch(input int d, input int t0, input desc_t ds, output int doneAt);
        logic [31:0] vals[8];
        int          gap;
        int          t;
        int          lastWrite;
        evt_t        e;
        gap     = (d == 0) ? 0 : 2;
        vals[0] = ds.pc;
        vals[1] = ds.grid[0];
        vals[2] = ds.grid[1];
        vals[3] = ds.grid[2];
        vals[4] = ds.block[0];
        vals[5] = ds.block[1];
        vals[6] = ds.block[2];
        vals[7] = ds.param;
        t = t0 + 1;
        lastWrite = t;
        for (int i = 0; i < 8; i++) begin
            if (!(DIFF_EN && (i < 7) && shOk[d][i] && (shVal[d][i] == vals[i]))) begin
                e = '{isDone: 1'b0, at: t, addr: addrOf(i), data: vals[i]};
                if (d == 0) expQ0.push_back(e); else expQ1.push_back(e);
                if (i < 7) begin
                    shOk[d][i]  = 1'b1;
                    shVal[d][i] = vals[i];
                end
                lastWrite = t;
                t = t + gap + 1;
            end
        end
        doneAt = lastWrite + 1;
        e = '{isDone: 1'b1, at: doneAt, addr: '0, data: 32'd0};
        if (d == 0) expQ0.push_back(e); else expQ1.push_back(e);
        busyFrom[d] = t0 + 1;
        busyTo[d]   = lastWrite;
    endtask

    // Reset taken at the end of the current cycle: nothing later may appear.
    task automatic abortModel();
        while (expQ0.size() != 0 && expQ0[expQ0.size()-1].at > cyc) void'(expQ0.pop_back());
        while (expQ1.size() != 0 && expQ1[expQ1.size()-1].at > cyc) void'(expQ1.pop_back());
        for (int d = 0; d < 2; d++) begin
            if (busyTo[d] > cyc) busyTo[d] = cyc;
            for (int i = 0; i < 7; i++) begin
                shOk[d][i]  = 1'b0;
                shVal[d][i] = 32'd0;
            end
        end
    endtask

    task automatic checkDut(input int d, input logic wv, input logic [AW-1:0] a, input logic [31:0] dt,
                            input logic dn, input logic bz, input logic rdy);
        evt_t  e;
        bit    have;
        bit    expBusy;
        string p;
        p    = $sformatf("dut%0d", d);
        have = 1'b0;
        e    = '{isDone: 1'b0, at: 0, addr: '0, data: 32'd0};
        if (d == 0) begin
            have = (expQ0.size() != 0);
            if (have) e = expQ0[0];
        end else begin
            have = (expQ1.size() != 0);
            if (have) e = expQ1[0];
        end
        expBusy = (cyc >= busyFrom[d]) && (cyc <= busyTo[d]);
        check({p, " busy"}, 32'(bz), 32'(expBusy));
        check({p, " req_ready"}, 32'(rdy), 32'(!expBusy));
        if (wv || dn) begin
            check({p, " event_expected"}, 32'(have), 32'd1);
            if (have) begin
                if (d == 0) void'(expQ0.pop_front()); else void'(expQ1.pop_front());
                check({p, " event_cycle"}, 32'(cyc), 32'(e.at));
                check({p, " done_vs_write"}, 32'(dn), 32'(e.isDone));
                if (!e.isDone) begin
                    check({p, " write_addr"}, 32'(a), 32'(e.addr));
                    check({p, " write_data"}, dt, e.data);
                end
            end
        end else begin
            check({p, " idle_addr"}, 32'(a), 32'd0);
            check({p, " idle_data"}, dt, 32'd0);
            if (have && (e.at <= cyc)) begin
                check({p, $sformatf(" missing_event@%0d", e.at)}, 32'(wv || dn), 32'd1);
                if (d == 0) void'(expQ0.pop_front()); else void'(expQ1.pop_front());
            end
        end
    endtask

    task automatic checkOutput();
        if (checksOn) begin
            checkDut(0, bus0.write_valid, bus0.write_addr, bus0.write_data, done0, busy0, reqReady0);
            checkDut(1, bus1.write_valid, bus1.write_addr, bus1.write_data, done1, busy1, reqReady1);
        end
    endtask

    // One clock: advance the cycle number, then sample outputs mid-cycle.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input int d, input bit valid, input desc_t ds);
        reqPc    = ds.pc;
        reqParam = ds.param;
        reqGrid  = ds.grid;
        reqBlock = ds.block;
        if (d == 0) reqValid0 = valid; else reqValid1 = valid;
    endtask

    // Single launch on one DUT, then run until its done pulse has been seen.
    task automatic runLaunch(input int d, input desc_t ds);
        int doneAt;
        applyStimulus(d, 1'b1, ds);
        pushLaunch(d, cyc, ds, doneAt);
        tick();
        applyStimulus(d, 1'b0, ds);
        for (int k = 0; k < 40 && cyc <= doneAt; k++) tick();
    endtask

    initial begin
        desc_t dA;
        desc_t dE;
        desc_t dF;
        desc_t dG;
        desc_t dH3;
        int    doneE;
        int    doneF;
        int    t0;

        errors    = 0;
        checks    = 0;
        cyc       = 0;
        checksOn  = 1'b0;
        reset     = 1'b1;
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        reqPc     = '0;
        reqParam  = '0;
        reqGrid   = '0;
        reqBlock  = '0;
        for (int d = 0; d < 2; d++) begin
            busyFrom[d] = 1;
            busyTo[d]   = 0;
            for (int i = 0; i < 7; i++) begin
                shOk[d][i]  = 1'b0;
                shVal[d][i] = 32'd0;
            end
        end

        dA  = makeDesc(32'h8000_0000, 32'h0000_1000, 32'd4, 32'd2, 32'd1, 32'd32, 32'd1, 32'd1);
        dE  = makeDesc(32'h8000_1000, 32'h0000_2000, 32'd8, 32'd2, 32'd1, 32'd32, 32'd1, 32'd1);
        dF  = makeDesc(32'h8000_2000, 32'h0000_3000, 32'd1, 32'd1, 32'd1, 32'd64, 32'd2, 32'd1);
        dG  = makeDesc(32'h9000_0000, 32'h0000_4000, 32'd2, 32'd2, 32'd2, 32'd16, 32'd16, 32'd1);
        dH3 = makeDesc(32'h8000_0000, 32'h0000_1000, 32'd4, 32'd3, 32'd1, 32'd32, 32'd1, 32'd1);

        $display("[TB] reset");
        repeat (3) tick();
        reset    = 1'b0;
        checksOn = 1'b1;
        repeat (2) tick();

        $display("[TB] gap 0 launch");
        runLaunch(0, dA);
        tick();

        $display("[TB] gap 2 launch");
        runLaunch(1, dA);
        tick();

        $display("[TB] back-to-back launches");
        applyStimulus(0, 1'b1, dE);
        pushLaunch(0, cyc, dE, doneE);
        tick();
        applyStimulus(0, 1'b1, dF);
        for (int k = 0; k < 40 && cyc < doneE; k++) tick();
        pushLaunch(0, cyc, dF, doneF);
        tick();
        applyStimulus(0, 1'b0, dF);
        for (int k = 0; k < 40 && cyc <= doneF; k++) tick();
        tick();

        $display("[TB] reset during launch");
        applyStimulus(0, 1'b1, dG);
        t0 = cyc;
        pushLaunch(0, t0, dG, doneE);
        tick();
        applyStimulus(0, 1'b0, dG);
        for (int k = 0; k < 10 && cyc < t0 + 4; k++) tick();
        reset = 1'b1;
        abortModel();
        tick();
        reset = 1'b0;
        repeat (12) tick();

        $display("[TB] repeated descriptors with reset in between");
        runLaunch(0, dA);
        tick();
        reset = 1'b1;
        abortModel();
        tick();
        reset = 1'b0;
        tick();
        runLaunch(0, dA);
        tick();
        runLaunch(0, dA);
        tick();
        runLaunch(0, dH3);
        repeat (4) tick();

        check("dut0 scoreboard_drained", 32'(expQ0.size()), 32'd0);
        check("dut1 scoreboard_drained", 32'(expQ1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
